// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared state encoding and operation-mode constants for add_sub_serial.
package add_sub_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational W-bit carry-lookahead adder, also exposing the carry into the top bit.
module cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         c0,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [W-1:0] p, g;
    logic [W:0]   c;
    assign p = x ^ y;
    assign g = x & y;
    assign c[0] = c0;
    // each carry is a flat sum of generate terms gated by the propagates above them
    for (genvar i = 1; i <= W; i++) begin : g_c
        logic [i:0] t;
        assign t[0] = c0 & (&p[i-1:0]);
        for (genvar j = 0; j < i; j++) begin : g_t
            if (j == i - 1) begin : g_top
                assign t[j+1] = g[j];
            end else begin : g_mid
                assign t[j+1] = g[j] & (&p[i-1:j+1]);
            end
        end
        assign c[i] = |t;
    end
    assign s     = p ^ c[W-1:0];
    assign cout  = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial two's-complement adder/subtractor, one SLICE-bit digit per clock.
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xr, yr, acc, acc_nx;
    logic             carry, dc, dm, last;
    logic [SLICE-1:0] ds;
    cla_slice #(.W(SLICE)) u_cla (
        .x(xr[SLICE-1:0]), .y(yr[SLICE-1:0]), .c0(carry),
        .s(ds), .cout(dc), .c_msb(dm)
    );
    // operands shift down so the active digit is always at the bottom; sum fills from the top
    assign acc_nx = WIDTH'({ds, acc} >> SLICE);
    assign last   = cnt == CW'(N - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            xr    <= '0;
            yr    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_RUN) begin
                xr    <= xr >> SLICE;
                yr    <= yr >> SLICE;
                acc   <= acc_nx;
                carry <= dc;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    s     <= acc_nx;
                    cout  <= dc;
                    ovf   <= dm ^ dc;
                    zero  <= acc_nx == '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
            end else if (start) begin
                xr    <= x;
                yr    <= add_sub == OP_SUB ? ~y : y;
                carry <= add_sub;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= S_RUN;
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial: directed and randomised checks of add_sub_serial at 16/4, 8/8 and 32/4.
module tb_add_sub_serial;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, add_sub = 1'b0;
    logic [15:0] x = '0, y = '0, s;
    logic busy, done, cout, ovf, zero;
    logic st8 = 1'b0, op8 = 1'b0, b8, d8, c8, v8, z8;
    logic [7:0] x8 = '0, y8 = '0, s8;
    logic st32 = 1'b0, op32 = 1'b0, b32, d32, c32, v32, z32;
    logic [31:0] x32 = '0, y32 = '0, s32;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    add_sub_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .add_sub(add_sub),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );
    add_sub_serial #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .x(x8), .y(y8), .add_sub(op8),
        .busy(b8), .done(d8), .s(s8), .cout(c8), .ovf(v8), .zero(z8)
    );
    add_sub_serial #(.WIDTH(32), .SLICE(4)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .x(x32), .y(y32), .add_sub(op32),
        .busy(b32), .done(d32), .s(s32), .cout(c32), .ovf(v32), .zero(z32)
    );

    // drives one operation from just after an edge; returns edges-to-done (incl. the start edge) and busy cycles
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                          output int lat, output int bc);
        x = a; y = b; add_sub = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bc = int'(busy);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            bc += int'(busy);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({busy, done, cout, ovf, zero, s} !== 21'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b ovf=%b zero=%b s=%h, want all 0",
                     busy, done, cout, ovf, zero, s);
        end
    endtask

    task automatic test_add;
        int lat, bc;
        run_op(16'h1234, 16'h0FFF, 1'b0, lat, bc);
        total++;
        if (lat !== 5 || bc !== 4) begin
            bad++; $display("FAIL add_timing: got lat=%0d busy=%0d, want 5 4", lat, bc);
        end
        total++;
        if ({s, cout, ovf, zero} !== {16'h2233, 3'b000}) begin
            bad++; $display("FAIL add_result: got s=%h c=%b v=%b z=%b, want 2233 0 0 0", s, cout, ovf, zero);
        end
    endtask

    task automatic test_sub_back_to_back;
        int lat, bc;
        run_op(16'h0005, 16'h0007, 1'b1, lat, bc);
        total++;
        if ({s, cout, ovf, zero} !== {16'hFFFE, 3'b000}) begin
            bad++; $display("FAIL sub_borrow: got s=%h c=%b v=%b z=%b, want fffe 0 0 0", s, cout, ovf, zero);
        end
        run_op(16'h0007, 16'h0007, 1'b1, lat, bc);
        total++;
        if (lat !== 5 || bc !== 4) begin
            bad++; $display("FAIL b2b_timing: got lat=%0d busy=%0d, want 5 4", lat, bc);
        end
        total++;
        if ({s, cout, ovf, zero} !== {16'h0000, 3'b101}) begin
            bad++; $display("FAIL sub_equal: got s=%h c=%b v=%b z=%b, want 0000 1 0 1", s, cout, ovf, zero);
        end
    endtask

    task automatic test_overflow;
        int lat, bc;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        total++;
        if ({s, cout, ovf, zero} !== {16'h8000, 3'b010}) begin
            bad++; $display("FAIL ovf_add: got s=%h c=%b v=%b z=%b, want 8000 0 1 0", s, cout, ovf, zero);
        end
        run_op(16'h8000, 16'h0001, 1'b1, lat, bc);
        total++;
        if ({s, cout, ovf, zero} !== {16'h7FFF, 3'b110}) begin
            bad++; $display("FAIL ovf_sub: got s=%h c=%b v=%b z=%b, want 7fff 1 1 0", s, cout, ovf, zero);
        end
    endtask

    task automatic test_wrap;
        int lat, bc;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        total++;
        if ({s, cout, ovf, zero} !== {16'h0000, 3'b101}) begin
            bad++; $display("FAIL carry_wrap: got s=%h c=%b v=%b z=%b, want 0000 1 0 1", s, cout, ovf, zero);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        x = 16'h1111; y = 16'h2222; add_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        x = 16'hAAAA; y = 16'h5555; add_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 5 || s !== 16'h3333) begin
            bad++; $display("FAIL start_in_run: got lat=%0d s=%h, want 5 3333", lat, s);
        end
        @(posedge clk); #1;
        total++;
        if ({done, busy} !== 2'b00 || s !== 16'h3333) begin
            bad++; $display("FAIL done_pulse: got done=%b busy=%b s=%h, want 0 0 3333", done, busy, s);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic seen;
        x = 16'h00FF; y = 16'h0001; add_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, cout, ovf, zero, s} !== 21'd0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b done=%b s=%h c=%b v=%b z=%b, want all 0",
                     busy, done, s, cout, ovf, zero);
        end
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen |= done | busy;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_done: got activity=%b, want 0", seen);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, lat, bc);
        total++;
        if (lat !== 5 || s !== 16'h0100 || {cout, ovf, zero} !== 3'b000) begin
            bad++; $display("FAIL after_reset: got lat=%0d s=%h c=%b v=%b z=%b, want 5 0100 0 0 0",
                            lat, s, cout, ovf, zero);
        end
    endtask

    task automatic test_sweep_w8;
        logic [7:0] yy;
        logic [8:0] r;
        logic ve;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            x8 = 8'($urandom); y8 = 8'($urandom); op8 = 1'($urandom);
            yy = op8 ? ~y8 : y8;
            r = {1'b0, x8} + {1'b0, yy} + 9'(op8);
            ve = (x8[7] == yy[7]) && (r[7] != x8[7]);
            st8 = 1'b1;
            @(posedge clk); #1;
            st8 = 1'b0;
            lat = 1;
            while (!d8 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            total++;
            if (lat !== 2) begin
                bad++; $display("FAIL w8_latency: got %0d, want 2", lat);
            end
            total++;
            if ({s8, c8, v8, z8} !== {r[7:0], r[8], ve, r[7:0] == 8'd0}) begin
                bad++;
                $display("FAIL w8_result: x=%h y=%h op=%b got s=%h c=%b v=%b z=%b, want %h %b %b",
                         x8, y8, op8, s8, c8, v8, z8, r[7:0], r[8], ve);
            end
        end
    endtask

    task automatic test_sweep_w32;
        logic [31:0] yy;
        logic [32:0] r;
        logic ve;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            x32 = $urandom; y32 = $urandom; op32 = 1'($urandom);
            if (k < 4) begin
                x32 = k[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                y32 = k[1] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            end
            yy = op32 ? ~y32 : y32;
            r = {1'b0, x32} + {1'b0, yy} + 33'(op32);
            ve = (x32[31] == yy[31]) && (r[31] != x32[31]);
            st32 = 1'b1;
            @(posedge clk); #1;
            st32 = 1'b0;
            lat = 1;
            while (!d32 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            total++;
            if (lat !== 9) begin
                bad++; $display("FAIL w32_latency: got %0d, want 9", lat);
            end
            total++;
            if ({s32, c32, v32, z32} !== {r[31:0], r[32], ve, r[31:0] == 32'd0}) begin
                bad++;
                $display("FAIL w32_result: x=%h y=%h op=%b got s=%h c=%b v=%b z=%b, want %h %b %b",
                         x32, y32, op32, s32, c32, v32, z32, r[31:0], r[32], ve);
            end
        end
    endtask

    initial begin
        #12;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_add;
        test_sub_back_to_back;
        test_overflow;
        test_wrap;
        test_ignore_start;
        test_reset_mid;
        test_sweep_w8;
        test_sweep_w32;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
